// File: rtl/avalon_len_limiter_pkg.sv
// Shared types and constants for the Avalon-ST packet length limiter.
package avalon_len_limiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IN_PKT,
    DROP
  } len_lim_state_t;

  localparam int unsigned STATS_W = 32;

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST bundle: valid/rdy handshake with packet framing, data and empty.
interface avalon_st_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned EMPTY_W = 2
);

  logic               valid;
  logic               rdy;
  logic               sop;
  logic               eop;
  logic [DATA_W-1:0]  data;
  logic [EMPTY_W-1:0] empty;

  modport master (output valid, sop, eop, data, empty, input rdy);
  modport slave  (input valid, sop, eop, data, empty, output rdy);

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/avalon_len_limiter.sv
// Zero-latency Avalon-ST length limiter: truncates packets at MAX_LEN, flags packets under MIN_LEN.
// Optional packet/truncation counters under AVALON_LEN_LIMITER_STATS_EN.
module avalon_len_limiter
  import avalon_len_limiter_pkg::*;
#(
  parameter  int unsigned MAX_LEN = 256,
  parameter  int unsigned MIN_LEN = 1,
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  avalon_st_if.slave         in_st,
  avalon_st_if.master        out_st,
  output logic               truncated_indc,
  output logic               short_pkt_indc
`ifdef AVALON_LEN_LIMITER_STATS_EN
  ,
  output logic [STATS_W-1:0] pkt_cnt,
  output logic [STATS_W-1:0] trunc_cnt
`endif
);

  len_lim_state_t   state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W:0]   beat_num;
  logic             at_max;
  logic             fwd;
  logic             accept;
  logic             trunc_d, short_d;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    trunc_d    = 1'b0;
    short_d    = 1'b0;

    // 1-based position this beat would occupy in the output packet
    beat_num = (state_q == IDLE) ? (CNT_W + 1)'(1) : {1'b0, beat_cnt_q} + (CNT_W + 1)'(1);
    at_max   = (beat_num == (CNT_W + 1)'(MAX_LEN));

    unique case (state_q)
      IDLE:    fwd = in_st.sop;
      IN_PKT:  fwd = 1'b1;
      DROP:    fwd = 1'b0;
      default: fwd = 1'b0;
    endcase

    in_st.rdy    = fwd ? out_st.rdy : 1'b1;
    out_st.valid = in_st.valid & fwd;
    out_st.sop   = out_st.valid & (state_q == IDLE);
    out_st.eop   = out_st.valid & (in_st.eop | at_max);
    out_st.data  = out_st.valid ? in_st.data : '0;
    // a forced eop always closes a full final word
    out_st.empty = (out_st.valid & in_st.eop) ? in_st.empty : '0;

    accept = in_st.valid & in_st.rdy;

    if (accept) begin
      if (fwd) begin
        beat_cnt_d = beat_num[CNT_W-1:0];
        if (in_st.eop) begin
          state_d = IDLE;
          short_d = (beat_num < (CNT_W + 1)'(MIN_LEN));
        end else if (at_max) begin
          state_d = DROP;
          trunc_d = 1'b1;
        end else begin
          state_d = IN_PKT;
        end
      end else if ((state_q == DROP) && in_st.eop) begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      beat_cnt_q     <= '0;
      truncated_indc <= 1'b0;
      short_pkt_indc <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      truncated_indc <= trunc_d;
      short_pkt_indc <= short_d;
    end
  end

`ifdef AVALON_LEN_LIMITER_STATS_EN
  logic pkt_inc;
  assign pkt_inc = out_st.valid & out_st.rdy & out_st.eop;

  sat_counter #(
    .WIDTH (STATS_W)
  ) u_pkt_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pkt_inc),
    .clr (1'b0),
    .cnt (pkt_cnt)
  );

  sat_counter #(
    .WIDTH (STATS_W)
  ) u_trunc_cnt (
    .clk (clk),
    .rst (rst),
    .inc (trunc_d),
    .clr (1'b0),
    .cnt (trunc_cnt)
  );
`endif

endmodule

// File: tb/tb_avalon_len_limiter.sv
// Directed bench for avalon_len_limiter (MAX_LEN=4, MIN_LEN=3) with an output-beat scoreboard.
module tb_avalon_len_limiter;
  import avalon_len_limiter_pkg::*;

  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned MIN_LEN = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  avalon_st_if #(.DATA_W(16), .EMPTY_W(2)) in_st ();
  avalon_st_if #(.DATA_W(16), .EMPTY_W(2)) out_st ();

  logic truncated_indc, short_pkt_indc;
`ifdef AVALON_LEN_LIMITER_STATS_EN
  logic [31:0] pkt_cnt, trunc_cnt;
`endif

  avalon_len_limiter #(
    .MAX_LEN (MAX_LEN),
    .MIN_LEN (MIN_LEN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_st          (in_st),
    .out_st         (out_st),
    .truncated_indc (truncated_indc),
    .short_pkt_indc (short_pkt_indc)
`ifdef AVALON_LEN_LIMITER_STATS_EN
    ,
    .pkt_cnt        (pkt_cnt),
    .trunc_cnt      (trunc_cnt)
`endif
  );

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [15:0] data;
    logic [1:0]  empty;
  } beat_t;

  beat_t exp_q[$];
  int    n_pass  = 0;
  int    n_total = 0;
  logic  pend_trunc = 1'b0, pend_short = 1'b0;
  logic  exp_trunc  = 1'b0, exp_short  = 1'b0;
  logic  toggle_en  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pulses expected the cycle after the triggering accept
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_trunc <= 1'b0;
      exp_short <= 1'b0;
    end else begin
      exp_trunc <= pend_trunc;
      exp_short <= pend_short;
    end
  end

  always @(negedge clk) begin
    beat_t e;
    chk("truncated_indc", 32'(truncated_indc), 32'(exp_trunc));
    chk("short_pkt_indc", 32'(short_pkt_indc), 32'(exp_short));
    if (out_st.valid && out_st.rdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'(out_st.valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("out_sop", 32'(out_st.sop), 32'(e.sop));
        chk("out_eop", 32'(out_st.eop), 32'(e.eop));
        chk("out_data", 32'(out_st.data), 32'(e.data));
        chk("out_empty", 32'(out_st.empty), 32'(e.empty));
      end
    end
    if (!out_st.valid) chk("idle_data_empty", 32'({out_st.data, out_st.empty}), 32'(0));
  end

  task automatic drive_beat(input logic sop, input logic eop, input logic [15:0] data,
                            input logic [1:0] empty, input logic fwd, input logic trunc,
                            input logic short);
    beat_t e;
    logic  done = 1'b0;
    in_st.valid = 1'b1;
    in_st.sop   = sop;
    in_st.eop   = eop;
    in_st.data  = data;
    in_st.empty = empty;
    if (fwd) begin
      e.sop   = sop;
      e.eop   = eop | trunc;
      e.data  = data;
      e.empty = eop ? empty : 2'd0;
      exp_q.push_back(e);
    end
    for (int c = 0; c < 40; c++) begin
      out_st.rdy = toggle_en ? ~out_st.rdy : 1'b1;
      @(negedge clk);
      chk("in_rdy", 32'(in_st.rdy), 32'(fwd ? out_st.rdy : 1'b1));
      if (!fwd) chk("drop_valid", 32'(out_st.valid), 32'(0));
      if (in_st.rdy) begin
        pend_trunc = trunc;
        pend_short = short;
        @(posedge clk);
        #1;
        pend_trunc = 1'b0;
        pend_short = 1'b0;
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 32'(done), 32'(1));
  endtask

  task automatic idle(input int n);
    in_st.valid = 1'b0;
    in_st.sop   = 1'b0;
    in_st.eop   = 1'b0;
    in_st.data  = '0;
    in_st.empty = '0;
    out_st.rdy  = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle_valid", 32'(out_st.valid), 32'(0));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pkt(input int len, input logic [15:0] base);
    for (int i = 1; i <= len; i++) begin
      drive_beat(i == 1, i == len, base + 16'(i), (i == len) ? 2'd1 : 2'd0,
                 i <= int'(MAX_LEN), (i == int'(MAX_LEN)) && (len > int'(MAX_LEN)),
                 (i == len) && (len < int'(MIN_LEN)));
    end
    idle(1);
  endtask

  initial begin
    in_st.valid = 1'b0;
    in_st.sop   = 1'b0;
    in_st.eop   = 1'b0;
    in_st.data  = '0;
    in_st.empty = '0;
    out_st.rdy  = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_trunc", 32'(truncated_indc), 32'(0));
    chk("reset_short", 32'(short_pkt_indc), 32'(0));
    chk("reset_valid", 32'(out_st.valid), 32'(0));
    chk("reset_state", 32'(dut.state_q), 32'(IDLE));
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    send_pkt(3, 16'h0100);
    chk("state_after_pkt", 32'(dut.state_q), 32'(IDLE));

    // stray non-sop beat in IDLE is swallowed
    drive_beat(1'b0, 1'b0, 16'h0BAD, 2'd0, 1'b0, 1'b0, 1'b0);
    idle(1);

    send_pkt(7, 16'h0200);
    send_pkt(3, 16'h0300);
    send_pkt(4, 16'h0400);
    send_pkt(2, 16'h0500);

    toggle_en = 1'b1;
    send_pkt(6, 16'h0600);
    toggle_en = 1'b0;

`ifdef AVALON_LEN_LIMITER_STATS_EN
    chk("pkt_cnt_pre_rst", pkt_cnt, 32'd6);
    chk("trunc_cnt_pre_rst", trunc_cnt, 32'd2);
`endif

    // reset in the middle of a 5-beat packet
    drive_beat(1'b1, 1'b0, 16'h0701, 2'd0, 1'b1, 1'b0, 1'b0);
    drive_beat(1'b0, 1'b0, 16'h0702, 2'd0, 1'b1, 1'b0, 1'b0);
    in_st.valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_trunc", 32'(truncated_indc), 32'(0));
    chk("midrst_short", 32'(short_pkt_indc), 32'(0));
    chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
`ifdef AVALON_LEN_LIMITER_STATS_EN
    chk("midrst_pkt_cnt", pkt_cnt, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    send_pkt(2, 16'h0800);
    chk("state_after_rst_pkt", 32'(dut.state_q), 32'(IDLE));
`ifdef AVALON_LEN_LIMITER_STATS_EN
    chk("pkt_cnt_post_rst", pkt_cnt, 32'd1);
    chk("trunc_cnt_post_rst", trunc_cnt, 32'd0);
`endif

    idle(2);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
